temporizador_ctrl: RTL

Sequencing controller wrapped around the 26-bit up-counter datapath: turns the free-running counter into a start/stop/pause-able timer with a programmable terminal value. Generates one-cycle `tick` pulses in one-shot or periodic mode. Sits between user control logic (buttons, UART commands) and anything needing timed events (LED blink, baud/period generators).

---
 rtl/temporizador_ctrl.sv | 83 ++++++++
 1 files changed

// File: rtl/temporizador_ctrl.sv
// temporizador_ctrl: turns a WIDTH-bit up-counter into a start/stop/pause-able
// timer with a programmable terminal value. It produces a one-cycle tick at the
// terminal count and runs in either one-shot or periodic (auto-reload) mode.
module temporizador_ctrl #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             periodic,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] limit_q;
  logic             periodic_q;

  // Sequencer: stop beats start, start beats pause, pause beats counting.
  // The terminal value and mode are captured only on an accepted start, so
  // limit/periodic may change freely while the timer runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      tick       <= 1'b0;
      limit_q    <= '0;
      periodic_q <= 1'b0;
    end else if (stop) begin
      state <= IDLE;
      count <= '0;
      tick  <= 1'b0;
    end else if (start && (limit != '0)) begin
      limit_q    <= limit;
      periodic_q <= periodic;
      state      <= RUN;
      count      <= '0;
      tick       <= 1'b0;
    end else begin
      tick <= 1'b0;
      case (state)
        RUN: begin
          if (pause) begin
            state <= HOLD;
          end else if (count == limit_q) begin
            count <= '0;
            tick  <= 1'b1;
            if (!periodic_q) begin
              state <= DONE;
            end
          end else begin
            count <= count + WIDTH'(1);
          end
        end
        HOLD: begin
          if (!pause) begin
            state <= RUN;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status flags are plain decodes of the state register, so they never
  // depend combinationally on any input.
  assign busy = (state == RUN) || (state == HOLD);
  assign done = (state == DONE);

endmodule
